// File: rtl/ewrapper_tx_arbiter_if.sv
// Requester/serializer bundle for the elink TX packet arbiter.
interface ewrapper_tx_arbiter_if #(
  parameter int unsigned NREQ = 2
) ();
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [64*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               tx_wait;
  logic [71:0]        tx_data;
  logic [NREQ-1:0]    grant;
  logic               proto_err;

  // Requester / environment side
  modport master (
    output req_valid, req_last, req_data, tx_wait,
    input  req_ready, tx_data, grant, proto_err
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_last, req_data, tx_wait,
    output req_ready, tx_data, grant, proto_err
  );
endinterface

// File: rtl/ewrapper_tx_arbiter.sv
// Round-robin packet arbiter and frame-lane generator feeding the elink TX serializer.
module ewrapper_tx_arbiter #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                 clk_div_in_i,
  input  logic                 reset_n_i,
  ewrapper_tx_arbiter_if.slave bus
);

  localparam int unsigned PTR_W   = $clog2(NREQ);
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned FRAME_W = 8;
  localparam int unsigned WORD_W  = FRAME_W + DATA_W;
  localparam int unsigned CNT_W   = 4;

  localparam logic [FRAME_W-1:0] FRAME_FIRST = 8'h7F;
  localparam logic [FRAME_W-1:0] FRAME_NEXT  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [WORD_W-1:0]   tx_data_q, tx_data_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                first_beat_q, first_beat_d;
  logic                proto_err_q, proto_err_d;

  logic                pick_found_c;
  logic [NREQ-1:0]     pick_oh_c;
  logic [PTR_W-1:0]    g_idx_c;
  logic [PTR_W-1:0]    g_next_c;
  logic                g_valid_c;
  logic                g_last_c;
  logic [DATA_W-1:0]   g_data_c;

  // First valid requester at or above the round-robin pointer, wrapping.
  always_comb begin
    int unsigned idx;
    idx          = 0;
    pick_found_c = 1'b0;
    pick_oh_c    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NREQ;
      if (!pick_found_c && bus.req_valid[PTR_W'(idx)]) begin
        pick_found_c            = 1'b1;
        pick_oh_c[PTR_W'(idx)]  = 1'b1;
      end
    end
  end

  // Beat signals of the current owner, selected by the one-hot grant.
  always_comb begin
    g_idx_c   = '0;
    g_valid_c = 1'b0;
    g_last_c  = 1'b0;
    g_data_c  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        g_idx_c   = PTR_W'(i);
        g_valid_c = bus.req_valid[i];
        g_last_c  = bus.req_last[i];
        g_data_c  = bus.req_data[DATA_W*i +: DATA_W];
      end
    end
    g_next_c = (g_idx_c == PTR_W'(NREQ - 1)) ? '0 : g_idx_c + 1'b1;
  end

  // Next-state and next-output logic; idle word unless a beat is accepted.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    tx_data_d    = '0;
    rr_ptr_d     = rr_ptr_q;
    gap_cnt_d    = gap_cnt_q;
    first_beat_d = first_beat_q;
    proto_err_d  = proto_err_q;

    unique case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (!bus.tx_wait && pick_found_c) begin
          grant_d      = pick_oh_c;
          first_beat_d = 1'b1;
          state_d      = ST_SEND;
        end
      end

      ST_SEND: begin
        if (g_valid_c) begin
          tx_data_d    = {(first_beat_q ? FRAME_FIRST : FRAME_NEXT), g_data_c};
          first_beat_d = 1'b0;
          if (g_last_c) begin
            rr_ptr_d = g_next_c;
            grant_d  = '0;
            if (GAP_CYCLES > 0) begin
              gap_cnt_d = CNT_W'(GAP_CYCLES);
              state_d   = ST_GAP;
            end else begin
              state_d   = ST_IDLE;
            end
          end
        end else begin
          // Mid-packet bubble: abandon the packet and pass ownership on.
          proto_err_d = 1'b1;
          grant_d     = '0;
          rr_ptr_d    = g_next_c;
          state_d     = ST_IDLE;
        end
      end

      ST_GAP: begin
        gap_cnt_d = gap_cnt_q - 1'b1;
        if (gap_cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_div_in_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      tx_data_q    <= '0;
      rr_ptr_q     <= '0;
      gap_cnt_q    <= '0;
      first_beat_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      tx_data_q    <= tx_data_d;
      rr_ptr_q     <= rr_ptr_d;
      gap_cnt_q    <= gap_cnt_d;
      first_beat_q <= first_beat_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // Grant is non-zero only while sending, so it doubles as the ready vector.
  assign bus.req_ready = grant_q;
  assign bus.grant     = grant_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_ewrapper_tx_arbiter.sv
// Bench for ewrapper_tx_arbiter: directed scenarios plus randomized packet streams.
module tb_ewrapper_tx_arbiter;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned GAP_B = 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ewrapper_tx_arbiter_if #(.NREQ(NREQ)) ifa ();
  ewrapper_tx_arbiter_if #(.NREQ(NREQ)) ifb ();

  ewrapper_tx_arbiter #(.NREQ(NREQ), .GAP_CYCLES(0)) dut_a (
    .clk_div_in_i (clk),
    .reset_n_i    (rst_n),
    .bus          (ifa.slave)
  );

  ewrapper_tx_arbiter #(.NREQ(NREQ), .GAP_CYCLES(GAP_B)) dut_b (
    .clk_div_in_i (clk),
    .reset_n_i    (rst_n),
    .bus          (ifb.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Stream stimulus and reference-model storage
  logic [63:0] sq_data [2][$];
  bit          sq_last [2][$];
  int          sq_len  [2][$];
  logic [63:0] md      [2][$];
  logic [71:0] ew      [$];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int r, input logic v, input logic l, input logic [63:0] d);
    ifa.req_valid[r]          = v;
    ifa.req_last[r]           = l;
    ifa.req_data[64*r +: 64]  = d;
  endtask

  task automatic set_b(input int r, input logic v, input logic l, input logic [63:0] d);
    ifb.req_valid[r]          = v;
    ifb.req_last[r]           = l;
    ifb.req_data[64*r +: 64]  = d;
  endtask

  task automatic chk_a(input string tag, input logic [71:0] tx, input logic [1:0] gnt);
    chk({tag, ".tx"},    ifa.tx_data,        tx);
    chk({tag, ".grant"}, 72'(ifa.grant),     72'(gnt));
    chk({tag, ".ready"}, 72'(ifa.req_ready), 72'(gnt));
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Present each requester's queue head; random remote wait if enabled.
  task automatic drive_stream(input bit wait_en);
    for (int r = 0; r < 2; r++) begin
      if (sq_data[r].size() > 0) set_a(r, 1'b1, sq_last[r][0], sq_data[r][0]);
      else                       set_a(r, 1'b0, 1'b0, 64'h0);
    end
    ifa.tx_wait = wait_en ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  // Queue packets on both requesters, predict the beat order, and check the output.
  task automatic run_stream(input string tag, input bit fixed, input bit wait_en);
    int ptr, r, len, zeros, cyc;
    bit started, wait_seen, w_now;
    logic [1:0]  hs;
    logic [71:0] w;
    for (int q = 0; q < 2; q++) begin
      int np;
      np = fixed ? 4 : int'($urandom_range(2, 5));
      for (int p = 0; p < np; p++) begin
        len = fixed ? 2 : int'($urandom_range(1, 4));
        sq_len[q].push_back(len);
        for (int b = 0; b < len; b++) begin
          sq_data[q].push_back(rnd64());
          sq_last[q].push_back(b == len - 1);
        end
      end
      md[q] = sq_data[q];
    end
    // Reference: round-robin over requesters with pending packets, whole packets at a time.
    ptr = 0;
    while (sq_len[0].size() + sq_len[1].size() > 0) begin
      r = -1;
      for (int k = 0; k < 2; k++)
        if (r < 0 && sq_len[(ptr + k) % 2].size() > 0) r = (ptr + k) % 2;
      len = sq_len[r].pop_front();
      for (int b = 0; b < len; b++)
        ew.push_back({(b == 0) ? 8'h7F : 8'hFF, md[r].pop_front()});
      ptr = (r + 1) % 2;
    end

    started = 1'b0; wait_seen = 1'b0; zeros = 0; cyc = 0;
    drive_stream(wait_en);
    while (ew.size() > 0 && cyc < 3000) begin
      hs    = ifa.req_valid & ifa.req_ready;
      w_now = ifa.tx_wait;
      tick();
      cyc++;
      for (int q = 0; q < 2; q++) begin
        if (hs[q]) begin
          void'(sq_data[q].pop_front());
          void'(sq_last[q].pop_front());
        end
      end
      w = ifa.tx_data;
      if (w != 72'h0) begin
        if (started) begin
          if (w[71:64] == 8'h7F) begin
            if (wait_seen) chk({tag, ".gap_min"}, 72'(zeros >= 1), 72'd1);
            else           chk({tag, ".gap"},     72'(zeros), 72'd1);
          end else begin
            chk({tag, ".contig"}, 72'(zeros), 72'd0);
          end
        end
        chk({tag, ".beat"}, w, ew.pop_front());
        started = 1'b1; zeros = 0; wait_seen = 1'b0;
      end else if (started) begin
        zeros++;
        if (w_now) wait_seen = 1'b1;
      end
      drive_stream(wait_en);
    end
    chk({tag, ".drain"}, 72'(ew.size()), 72'd0);
    chk({tag, ".perr"},  72'(ifa.proto_err), 72'd0);
    ew.delete();
    for (int q = 0; q < 2; q++) begin
      sq_data[q].delete(); sq_last[q].delete(); sq_len[q].delete(); md[q].delete();
    end
    set_a(0, 1'b0, 1'b0, 64'h0);
    set_a(1, 1'b0, 1'b0, 64'h0);
    ifa.tx_wait = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    logic [63:0] d0, d1, d2, d3;

    rst_n         = 1'b1;
    ifa.req_valid = '0; ifa.req_last = '0; ifa.req_data = '0; ifa.tx_wait = 1'b0;
    ifb.req_valid = '0; ifb.req_last = '0; ifb.req_data = '0; ifb.tx_wait = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk_a("reset", 72'h0, 2'b00);
    chk("reset.perr", 72'(ifa.proto_err), 72'd0);
    chk("reset.b.tx", ifb.tx_data, 72'h0);
    rst_n = 1'b1;
    tick();

    // Single 3-beat packet from requester 0
    d0 = rnd64(); d1 = rnd64(); d2 = rnd64();
    set_a(0, 1'b1, 1'b0, d0);
    tick(); chk_a("p3.grant", 72'h0, 2'b01);
    tick(); chk_a("p3.b0", {8'h7F, d0}, 2'b01);
    set_a(0, 1'b1, 1'b0, d1);
    tick(); chk_a("p3.b1", {8'hFF, d1}, 2'b01);
    set_a(0, 1'b1, 1'b1, d2);
    tick(); chk_a("p3.b2", {8'hFF, d2}, 2'b00);
    set_a(0, 1'b0, 1'b0, 64'h0);
    tick(); chk_a("p3.idle", 72'h0, 2'b00);

    // Both requesters saturated with 2-beat packets, then random streams
    do_reset(); run_stream("rr",    1'b1, 1'b0);
    do_reset(); run_stream("rnd0",  1'b0, 1'b0);
    do_reset(); run_stream("rndw1", 1'b0, 1'b1);
    do_reset(); run_stream("rndw2", 1'b0, 1'b1);

    // Remote wait blocks grants in IDLE but not a packet in flight
    do_reset();
    d0 = rnd64(); d1 = rnd64(); d2 = rnd64(); d3 = rnd64();
    ifa.tx_wait = 1'b1;
    set_a(0, 1'b1, 1'b0, d0);
    set_a(1, 1'b1, 1'b1, d3);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_a("wait.hold", 72'h0, 2'b00);
    end
    ifa.tx_wait = 1'b0;
    tick(); chk_a("wait.grant", 72'h0, 2'b01);
    ifa.tx_wait = 1'b1;
    tick(); chk_a("wait.b0", {8'h7F, d0}, 2'b01);
    set_a(0, 1'b1, 1'b0, d1);
    tick(); chk_a("wait.b1", {8'hFF, d1}, 2'b01);
    set_a(0, 1'b1, 1'b1, d2);
    tick(); chk_a("wait.b2", {8'hFF, d2}, 2'b00);
    set_a(0, 1'b0, 1'b0, 64'h0);
    tick(); chk_a("wait.blk0", 72'h0, 2'b00);
    tick(); chk_a("wait.blk1", 72'h0, 2'b00);
    ifa.tx_wait = 1'b0;
    tick(); chk_a("wait.g1", 72'h0, 2'b10);
    tick(); chk_a("wait.r1", {8'h7F, d3}, 2'b00);
    set_a(1, 1'b0, 1'b0, 64'h0);
    tick();

    // Requester 1 bubbles after its first beat
    do_reset();
    d0 = rnd64(); d1 = rnd64(); d2 = rnd64();
    set_a(1, 1'b1, 1'b0, d0);
    tick(); chk_a("bub.grant", 72'h0, 2'b10);
    tick(); chk_a("bub.b0", {8'h7F, d0}, 2'b10);
    set_a(1, 1'b0, 1'b0, 64'h0);
    tick(); chk_a("bub.idle", 72'h0, 2'b00);
    chk("bub.perr", 72'(ifa.proto_err), 72'd1);
    set_a(0, 1'b1, 1'b1, d1);
    set_a(1, 1'b1, 1'b1, d2);
    tick(); chk_a("bub.ptr", 72'h0, 2'b01);
    tick(); chk_a("bub.r0", {8'h7F, d1}, 2'b00);
    set_a(0, 1'b0, 1'b0, 64'h0);
    tick(); chk_a("bub.g1", 72'h0, 2'b10);
    tick(); chk_a("bub.restart", {8'h7F, d2}, 2'b00);
    chk("bub.sticky", 72'(ifa.proto_err), 72'd1);
    set_a(1, 1'b0, 1'b0, 64'h0);
    tick();

    // GAP_CYCLES=3: single-beat packets separated by 4 idle words
    d0 = rnd64(); d1 = rnd64();
    set_b(0, 1'b1, 1'b1, d0);
    tick(); chk("gap.grant", 72'(ifb.grant), 72'd1);
    tick(); chk("gap.p0", ifb.tx_data, {8'h7F, d0});
    set_b(0, 1'b1, 1'b1, d1);
    for (int i = 0; i < 4; i++) begin
      tick(); chk($sformatf("gap.idle%0d", i), ifb.tx_data, 72'h0);
    end
    tick(); chk("gap.p1", ifb.tx_data, {8'h7F, d1});
    set_b(0, 1'b0, 1'b0, 64'h0);
    tick();

    // Reset during the second beat of a 4-beat packet
    do_reset();
    d0 = rnd64(); d1 = rnd64(); d2 = rnd64(); d3 = rnd64();
    set_a(0, 1'b1, 1'b0, d0);
    set_a(1, 1'b1, 1'b1, d3);
    tick(); chk_a("rst.grant", 72'h0, 2'b01);
    tick(); chk_a("rst.b0", {8'h7F, d0}, 2'b01);
    set_a(0, 1'b1, 1'b0, d1);
    tick(); chk_a("rst.b1", {8'hFF, d1}, 2'b01);
    rst_n = 1'b0;
    #1;
    chk_a("rst.async", 72'h0, 2'b00);
    tick();
    rst_n = 1'b1;
    set_a(0, 1'b1, 1'b0, d2);
    tick(); chk_a("rst.regrant", 72'h0, 2'b01);
    tick(); chk_a("rst.restart", {8'h7F, d2}, 2'b01);
    set_a(0, 1'b0, 1'b0, 64'h0);
    set_a(1, 1'b0, 1'b0, 64'h0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ewrapper_tx_arbiter.md
# ewrapper_tx_arbiter

Packet arbiter and framer in front of the elink TX serializer. Shares the single 72-bit per-core-clock TX word (8 frame bits plus 64 data bits) among NREQ requesters, using round-robin selection with a per-packet grant lock. Generates the frame-lane byte pattern, enforces inter-packet idle gaps, and honours the remote wait signal. Runs entirely in the slow core clock domain and drives the serializer's 72-bit data input directly.

## Interface
- NREQ, 2: number of requesters, 2..4.
- GAP_CYCLES, 0: extra idle words after each packet, 0..15, on top of the mandatory arbitration idle word.

- CLK_DIV_IN  in  1  slow core clock, the same clock the serializer uses to capture its 72-bit input
- RESET_N  in  1  asynchronous, active-low reset
- REQ_VALID  in  NREQ  per-requester beat valid
- REQ_LAST  in  NREQ  marks the final beat of a packet; qualified by REQ_VALID
- REQ_DATA  in  64*NREQ  beat payload; requester i occupies [64*i+63:64*i]
- REQ_READY  out  NREQ  beat accepted when REQ_VALID[i] & REQ_READY[i]
- TX_WAIT  in  1  remote back-pressure, synchronous to CLK_DIV_IN
- TX_DATA  out  72  serializer word: [71:64] frame byte, [63:0] data; bit 71 is serialized first on the frame lane
- GRANT  out  NREQ  one-hot, the currently owning requester; all zero when no requester owns the link
- PROTO_ERR  out  1  sticky; set on a mid-packet bubble

## Operation
- States: IDLE, SEND, GAP. All outputs are registered or decoded from state registers only, with no combinational input-to-output path.
- IDLE:
  - TX_DATA = 72'h0 (idle word); GRANT = 0; REQ_READY = 0.
  - If !TX_WAIT and any REQ_VALID: pick the first valid requester searching upward from rr_ptr, wrapping NREQ-1 to 0. Load GRANT one-hot, clear first_beat flag to 1, go to SEND.
  - TX_WAIT is sampled in IDLE only.
- SEND:
  - REQ_READY = GRANT; all other requesters stay not-ready.
  - On handshake: TX_DATA <= {frame, REQ_DATA[g]}. Frame is 8'h7F on the first beat and 8'hFF on later beats. first_beat <= 0.
  - On a handshake with REQ_LAST: rr_ptr <= g+1 mod NREQ and GRANT <= 0. Go to GAP with gap_cnt <= GAP_CYCLES if GAP_CYCLES > 0; otherwise go to IDLE.
  - If the granted REQ_VALID is low in SEND (bubble, including the first cycle after grant): TX_DATA <= 72'h0, PROTO_ERR <= 1, GRANT <= 0, rr_ptr <= g+1, go to IDLE. The requester's remaining beats start a new packet with frame 8'h7F.
  - TX_WAIT asserted during SEND does not stall the packet in flight.
- GAP: TX_DATA = 72'h0; gap_cnt decrements each cycle; on reaching 1, go to IDLE.
- Packets have no length limit. A single-beat packet (REQ_LAST on the first beat) is legal and uses frame 8'h7F.
- PROTO_ERR clears only on reset.

## Timing
- Reset (async assert, deasserted synchronously by upstream): state=IDLE, TX_DATA=0, GRANT=0, REQ_READY=0, PROTO_ERR=0, rr_ptr=0, gap_cnt=0.
- Reset asserted mid-packet aborts the packet immediately. TX_DATA becomes 0 asynchronously.
- Grant latency: requester valid in IDLE leads to GRANT and REQ_READY in the next cycle.
- Data latency: the beat accepted at edge N appears on TX_DATA after edge N (1 cycle).
- Minimum idle words between packets: 1 + GAP_CYCLES. Back-to-back sustained rate per packet of L beats: L words out of L+1+GAP_CYCLES cycles.
- Simultaneous requests: the round-robin pointer decides. A requester raising valid while another is granted waits until its turn.
- TX_WAIT rising in the same cycle the arbiter is in IDLE blocks that grant. TX_WAIT falling permits a grant on the same edge it is seen low.

## Test plan
- Reset, single requester 0, 3-beat packet D0..D2, GAP_CYCLES=0 -> TX_DATA = {7F,D0},{FF,D1},{FF,D2}, then 72'h0 for at least 1 cycle; GRANT=01 for exactly 3 cycles.
- NREQ=2, both requesters continuously valid with 2-beat packets -> grants alternate 0,1,0,1; exactly one idle word between packets; no starvation over 8 packets.
- TX_WAIT=1 while both requesters are valid -> TX_DATA stays 0 and GRANT stays 0. Drop TX_WAIT -> grant to requester 0 the next cycle. Raise TX_WAIT mid-packet -> the packet completes unstalled.
- Requester 1 drops valid after its first beat -> an idle word is emitted, PROTO_ERR=1 (sticky), rr_ptr moves to 0, and requester 1's next beat restarts with frame 8'h7F.
- GAP_CYCLES=3 with single-beat packets from requester 0 -> TX_DATA pattern {7F,D}, then 4 idle words, then {7F,D'}.
- RESET_N pulsed low during the second beat of a 4-beat packet -> TX_DATA=0, GRANT=0, REQ_READY=0 immediately. After release, the next packet starts with frame 8'h7F from requester 0.
